seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-bus seven-segment display.
- Holds an N-digit hex value and shares one instance of the existing hex decoder sev_segment_drvr across all digits.
- Drives one digit at a time, with a blanking gap between digits to prevent ghosting.
- New values are accepted by a valid/ready handshake and applied only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- SHOW_CYCLES, 1000, clock cycles a digit is lit per slot; must be >= 1.
- BLANK_CYCLES, 16, clock cycles all digits are dark before each digit is lit; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = scan the display; 0 = all digits dark.
- blank_lz  in  1  1 = blank leading zeros.
- value_in  in  4*NUM_DIGITS  hex value; nibble i drives digit i, digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, captured together with value_in.
- value_valid  in  1  value_in/dp_in are valid.
- value_ready  out  1  controller can accept a value.
- ss_pattern_out  out  7  segments {a,b,c,d,e,f,g}, active-high, a is the MSB.
- dp_out  out  1  decimal point for the lit digit.
- digit_en_out  out  NUM_DIGITS  one-hot digit enable, active-high; all zero when dark.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - ss_pattern_out=0, dp_out=0, digit_en_out=0, frame_done=0, value_ready=0.
  - FSM=IDLE, digit index=0, slot counter=0.
  - Display register=0, dp register=0, pending buffer empty.
- value_ready:
  - Registered.
  - Rises the first clk after rst_n deasserts.
  - Otherwise equals "pending buffer empty".
- Handshake:
  - value_valid & value_ready captures value_in/dp_in into the pending buffer.
  - value_ready falls the next cycle.
  - value_valid with value_ready=0 is ignored; the source must hold its value.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: all outputs dark. If pending is full, transfer it to the display register and empty pending. enable=1 -> BLANK with index 0.
  - BLANK: lasts BLANK_CYCLES cycles; digit_en_out=0, segments=0. Then -> SHOW.
  - SHOW: lasts SHOW_CYCLES cycles. digit_en_out has bit[index] set. ss_pattern_out = decode(nibble[index]). dp_out = dp[index].
  - End of SHOW, index < NUM_DIGITS-1: index+1 -> BLANK.
  - End of SHOW, index = NUM_DIGITS-1: index wraps to 0, frame_done pulses, and the pending transfer occurs in that same cycle if pending is full. Then -> BLANK.
- Slot and frame length: slot = BLANK_CYCLES+SHOW_CYCLES cycles; frame = NUM_DIGITS*slot.
- Pending transfer and capture in the same cycle:
  - The transfer uses pending state as it was at the start of the cycle.
  - A capture in the same cycle as a transfer cannot happen, because ready was 0.
  - A capture made after a transfer waits for the next frame boundary.
- enable deasserted in BLANK or SHOW:
  - Next cycle -> IDLE; outputs dark, index=0, counter=0.
  - The pending buffer is retained.
  - A later enable=1 restarts at digit 0 BLANK.
- Leading-zero blanking:
  - Applies when blank_lz=1 and index != 0, and nibbles index..NUM_DIGITS-1 of the display register are all zero.
  - Then ss_pattern_out=0 and dp_out=dp[index]. digit_en_out still follows the normal timing.
  - Digit 0 is never blanked.
- Timing: all outputs are registered. State, index and decode update together, so the segments and the enable change in the same cycle and there are no glitches.
- Reset asserted mid-operation: everything returns immediately to reset values and any pending value is lost.

Decomposition:
- Shared package seg_pkg:
  - Segment width constant SEG_W=7.
  - FSM state typedef (IDLE/BLANK/SHOW).
  - Constant SEG_OFF=7'b0.
- Sub-module: one instance of sev_segment_drvr, fed by the nibble mux on index. Its output is registered inside seg_scan_ctrl.

Test Plan:
Bench parameters: NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=2, so slot=6 and frame=24.
- Reset and first frame:
  - Stimulus: hold rst_n=0, release with enable=1, then load value 16'h0123 with blank_lz=0.
  - During reset: all outputs are 0.
  - value_ready=1 one cycle after release.
  - After the load reaches the display register, per slot: 2 dark cycles, then digit_en_out=0001 with ss=7'h79, then 0010 with 7'h6D, 0100 with 7'h30, 1000 with 7'h7E.
  - frame_done pulses once every 24 cycles.
- Tear-free update:
  - Stimulus: load 16'hFFFF mid-frame while 16'h0123 is displayed.
  - value_ready=0 until the frame boundary.
  - The remaining digits of the current frame still show 0123.
  - The next frame shows 7'h47 on all four digits.
  - value_ready=1 the cycle after frame_done.
- Leading zeros:
  - Stimulus: value 16'h0005, blank_lz=1, dp_in=4'b0100.
  - Digits 3 and 1 have ss=0.
  - Digit 2 has ss=0 and dp_out=1.
  - Digit 0 has ss=7'h5B.
  - Stimulus: value 16'h0000 -> only digit 0 is lit, showing 7'h7E.
- Enable drop:
  - Stimulus: enable=0 during digit 2 SHOW.
  - Next cycle: digit_en_out=0 and ss=0.
  - A value loaded while enable=0 is applied in IDLE.
  - On re-enable: 2 dark cycles, then digit 0 lit with the new value.
- Backpressure:
  - Stimulus: hold value_valid=1 with two different values back to back.
  - The second value is not captured until value_ready returns.
  - No value is lost or duplicated, checked by the scoreboard.
- Asynchronous reset mid-SHOW:
  - Stimulus: assert rst_n=0 mid-SHOW with a pending value present.
  - All outputs are 0 without waiting for a clk edge.
  - After release, the display shows 0 and the pending value is gone.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sev_segment_drvr.sv
// Hex nibble to seven-segment decoder, segments {a,b,c,d,e,f,g}, active-high.
module sev_segment_drvr
    import seg_pkg::*;
(
    input  logic [3:0]       hex_in,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (hex_in)
            4'h0:    seg_c = 7'h7E;
            4'h1:    seg_c = 7'h30;
            4'h2:    seg_c = 7'h6D;
            4'h3:    seg_c = 7'h79;
            4'h4:    seg_c = 7'h33;
            4'h5:    seg_c = 7'h5B;
            4'h6:    seg_c = 7'h5F;
            4'h7:    seg_c = 7'h70;
            4'h8:    seg_c = 7'h7F;
            4'h9:    seg_c = 7'h7B;
            4'hA:    seg_c = 7'h77;
            4'hB:    seg_c = 7'h1F;
            4'hC:    seg_c = 7'h4E;
            4'hD:    seg_c = 7'h3D;
            4'hE:    seg_c = 7'h4F;
            4'hF:    seg_c = 7'h47;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-bus multi-digit seven-segment display.
// New values are double-buffered and only take effect at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SHOW_CYCLES  = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [SEG_W-1:0]        ss_pattern_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en_out,
    output logic                    frame_done
);

    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_END  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [VAL_W-1:0]      disp_q, disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [VAL_W-1:0]      pend_q, pend_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_full_q, pend_full_d;

    logic xfer;
    logic cap;

    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic [NUM_DIGITS-1:0] en_sel;
    logic                  upper_zero;
    logic                  lz_blank;
    logic [SEG_W-1:0]      dec_seg_c;

    logic [SEG_W-1:0]      seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] en_d;
    logic                  fd_d;

    // Scan sequencing: IDLE -> (BLANK -> SHOW) per digit, wrapping at the last digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                xfer  = pend_full_q;
                if (enable) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_END) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_END) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        xfer  = pend_full_q;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending buffer; a capture can never coincide with a transfer since ready is low while full.
    always_comb begin
        cap         = value_valid && value_ready;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        if (xfer) begin
            disp_d      = pend_q;
            disp_dp_d   = pend_dp_q;
            pend_full_d = 1'b0;
        end
        if (cap) begin
            pend_d      = value_in;
            pend_dp_d   = dp_in;
            pend_full_d = 1'b1;
        end
    end

    // Digit select and leading-zero detection for the digit about to be driven.
    always_comb begin
        nib_sel    = 4'h0;
        dp_sel     = 1'b0;
        en_sel     = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_d) begin
                nib_sel   = disp_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                en_sel[i] = 1'b1;
            end
            if ((IDX_W'(i) >= idx_d) && (disp_q[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        lz_blank = blank_lz && (idx_d != '0) && upper_zero;
    end

    sev_segment_drvr u_dec (
        .hex_in (nib_sel),
        .seg_c  (dec_seg_c)
    );

    // Next output values follow the next state so enables and segments switch together.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        en_d  = '0;
        fd_d  = 1'b0;
        if (state_d == SHOW) begin
            en_d  = en_sel;
            seg_d = lz_blank ? SEG_OFF : dec_seg_c;
            dp_d  = dp_sel;
            fd_d  = (idx_d == LAST_IDX) && (cnt_d == SHOW_END);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
        end else begin
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_ready    <= 1'b0;
            ss_pattern_out <= SEG_OFF;
            dp_out         <= 1'b0;
            digit_en_out   <= '0;
            frame_done     <= 1'b0;
        end else begin
            value_ready    <= !pend_full_d;
            ss_pattern_out <= seg_d;
            dp_out         <= dp_d;
            digit_en_out   <= en_d;
            frame_done     <= fd_d;
        end
    end

endmodule
